// File: rtl/skylark_seg7_pkg.sv
// Shared register map, segment encodings and digit-code type for the 7-segment display controller.
package skylark_seg7_pkg;

  localparam logic [1:0] REG_VALUE  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_DPMASK = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DEC  = 1;
  localparam int CTRL_LZB  = 2;
  localparam int STAT_BUSY = 0;
  localparam int STAT_OVF  = 1;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low GFEDCBA patterns, index 15 first so SEG_HEX[n] is glyph n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic       blank;
    logic       dash;
    logic [3:0] val;
  } digit_t;

  function automatic logic [6:0] seg_encode(input digit_t d);
    if (d.blank)     return SEG_BLANK;
    else if (d.dash) return SEG_DASH;
    else             return SEG_HEX[d.val];
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble: 32-bit binary to 10 BCD digits, one bit per cycle, 32 busy cycles.
// done is asserted during the last busy cycle with bcd already holding the final result.
module seg7_bin2bcd (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd
);

  logic [31:0] sh_q;
  logic [38:0] acc_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic [35:0] adj;

  // The top digit of a 32-bit value never exceeds 4, so it needs no add-3 stage and its MSB stays zero.
  always_comb begin
    adj = '0;
    for (int i = 0; i < 9; i++) begin
      adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end
  end

  assign bcd  = {acc_q[38:36], adj, sh_q[31]};
  assign busy = busy_q;
  assign done = busy_q & (cnt_q == 5'd31) & ~start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      sh_q   <= bin;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= bcd[38:0];
      sh_q  <= {sh_q[30:0], 1'b0};
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seg7_mmio_ctrl.sv
// Memory-mapped multi-digit 7-segment controller: hex or decimal (double-dabble) display with scan.
// Shadow loads one edge after a VALUE/CTRL write (hex) or when BUSY falls (decimal); outputs registered.
module seg7_mmio_ctrl
  import skylark_seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 262144
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sel,
  input  logic                  we,
  input  logic [1:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [31:0]           value_q;
  logic                  en_q, dec_q, lzb_q;
  logic [NUM_DIGITS-1:0] dpmask_q;
  logic                  upd_q;
  logic                  ovf_q;
  digit_t [NUM_DIGITS-1:0] shadow_q, load_dig;
  logic                  load_ovf, conv_ovf, zero_above;
  logic [DIV_W-1:0]      div_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  conv_busy, conv_done;
  logic [39:0]           conv_bcd;
  digit_t                cur;
  logic                  lit;
  logic                  wr;

  assign wr = sel & we;

  seg7_bin2bcd u_bin2bcd (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (upd_q & dec_q),
    .bin    (value_q),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        REG_VALUE:  rdata = value_q;
        REG_CTRL:   rdata[2:0] = {lzb_q, dec_q, en_q};
        REG_DPMASK: rdata[NUM_DIGITS-1:0] = dpmask_q;
        default:    rdata[1:0] = {ovf_q, conv_busy};
      endcase
    end
  end

  // Candidate shadow contents from whichever source the current mode selects.
  always_comb begin
    conv_ovf = 1'b0;
    for (int i = NUM_DIGITS; i < 10; i++) begin
      conv_ovf = conv_ovf | (conv_bcd[4*i +: 4] != 4'd0);
    end
    load_ovf = dec_q & conv_ovf;
    load_dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_dig[i].val  = dec_q ? conv_bcd[4*i +: 4] : value_q[4*i +: 4];
      load_dig[i].dash = load_ovf;
    end
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above         = zero_above & (load_dig[i].val == 4'd0);
      load_dig[i].blank  = lzb_q & ~load_ovf & zero_above;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q  <= '0;
      en_q     <= 1'b1;
      dec_q    <= 1'b0;
      lzb_q    <= 1'b0;
      dpmask_q <= '0;
      upd_q    <= 1'b0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          REG_VALUE:  value_q <= wdata;
          REG_CTRL: begin
            en_q  <= wdata[CTRL_EN];
            dec_q <= wdata[CTRL_DEC];
            lzb_q <= wdata[CTRL_LZB];
          end
          REG_DPMASK: dpmask_q <= wdata[NUM_DIGITS-1:0];
          default: ;
        endcase
      end
      upd_q <= wr & ((addr == REG_VALUE) | (addr == REG_CTRL));
      if ((upd_q & ~dec_q) | (conv_done & dec_q)) begin
        shadow_q <= load_dig;
        ovf_q    <= load_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign cur = shadow_q[idx_q];
  assign lit = en_q & ~cur.blank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      seg <= seg_encode(cur);
      dp  <= lit ? ~dpmask_q[idx_q] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_mmio_ctrl.sv
// Self-checking bench for seg7_mmio_ctrl: vector table, multi-cycle sequences and randomized model checks.
module tb_seg7_mmio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;

  seg7_mmio_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] value;
    logic [3:0]  dpm;
    logic [27:0] eseg;
    logic [3:0]  elit;
    logic [3:0]  edpl;
    logic        eovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // Display model from the number itself: digit i = (n / radix^i) % radix.
  function automatic void model(input logic [2:0] ctrl, input logic [31:0] value, input logic [3:0] dpm,
                                output logic [27:0] segs, output logic [3:0] lit,
                                output logic [3:0] dpl, output logic ovf);
    longint unsigned shown, base, radix;
    logic blank;
    radix = ctrl[1] ? 64'd10 : 64'd16;
    shown = ctrl[1] ? {32'd0, value} : {48'd0, value[15:0]};
    ovf   = ctrl[1] && (shown >= 64'd10000);
    segs = '0; lit = '0; dpl = '0; base = 1;
    for (int i = 0; i < 4; i++) begin
      blank  = (i > 0) && ctrl[2] && !ovf && (shown < base);
      lit[i] = ctrl[0] && !blank;
      if (lit[i]) segs[7*i +: 7] = ovf ? 7'h3F : seg_of(int'((shown / base) % radix));
      dpl[i] = lit[i] && dpm[i];
      base   = base * radix;
    end
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    #1; sel = 1'b1; we = 1'b0; addr = a;
    #1; d = rdata;
    sel = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    #1; sel = 1'b1; we = 1'b0; addr = 2'd3; #1;
    while (rdata[0] && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("busy_idle", rdata[0], 1'b0);
    sel = 1'b0;
  endtask

  task automatic capture(output logic [27:0] segs, output logic [3:0] lit,
                         output logic [3:0] dpl, output logic onehot_ok);
    segs = '0; lit = '0; dpl = '0; onehot_ok = 1'b1;
    repeat (16) begin
      @(posedge clk); #1;
      if (an != 4'hF) begin
        if ($countones(~an) != 1) onehot_ok = 1'b0;
        else for (int k = 0; k < 4; k++) if (!an[k]) begin
          lit[k] = 1'b1;
          segs[7*k +: 7] = seg;
          if (!dp) dpl[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [27:0] eseg, input logic [3:0] elit,
                             input logic [3:0] edpl, input logic eovf);
    logic [27:0] s; logic [3:0] l, d; logic ok; logic [31:0] st;
    capture(s, l, d, ok);
    check({tag, "_onehot"}, ok, 1'b1);
    check({tag, "_lit"}, l, elit);
    check({tag, "_seg"}, s, eseg);
    check({tag, "_dp"}, d, edpl);
    rd(2'd3, st);
    check({tag, "_status"}, st, {30'd0, eovf, 1'b0});
  endtask

  task automatic run_vec(input string tag, input logic [2:0] ctrl, input logic [31:0] value,
                         input logic [3:0] dpm, input logic [27:0] eseg, input logic [3:0] elit,
                         input logic [3:0] edpl, input logic eovf);
    wr(2'd2, {28'd0, dpm});
    wr(2'd1, {29'd0, ctrl});
    wr(2'd0, value);
    wait_idle();
    repeat (3) @(posedge clk);
    check_frame(tag, eseg, elit, edpl, eovf);
  endtask

  task automatic monitor(input logic [27:0] hold, output int cnt, output int first, output int last,
                         output logic persist_ok, output logic saw_one3);
    cnt = 0; first = 0; last = 0; persist_ok = 1'b1; saw_one3 = 1'b0;
    sel = 1'b1; we = 1'b0; addr = 2'd3;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (rdata[0]) begin
        cnt++;
        if (first == 0) first = k;
        last = k;
      end
      for (int j = 0; j < 4; j++) if (an != 4'hF && !an[j]) begin
        if (rdata[0] && seg != hold[7*j +: 7]) persist_ok = 1'b0;
        if (j == 3 && seg == 7'h79) saw_one3 = 1'b1;
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    logic [27:0] ms; logic [3:0] ml, md; logic mo;
    logic [31:0] rv, val; logic [2:0] c; logic [3:0] dm;
    int cnt, first, last; logic pok, saw;

    reset_n = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    vecs[0]  = '{3'd1, 32'h0000_1A2F, 4'h0, {7'h79, 7'h08, 7'h24, 7'h0E}, 4'hF, 4'h0, 1'b0};
    vecs[1]  = '{3'd3, 32'd1234,      4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0, 1'b0};
    vecs[2]  = '{3'd3, 32'd10000,     4'h4, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'hF, 4'h4, 1'b1};
    vecs[3]  = '{3'd7, 32'd7,         4'h3, {7'h00, 7'h00, 7'h00, 7'h78}, 4'h1, 4'h1, 1'b0};
    vecs[4]  = '{3'd6, 32'd7,         4'hF, 28'd0,                        4'h0, 4'h0, 1'b0};
    vecs[5]  = '{3'd5, 32'h0000_0305, 4'h0, {7'h00, 7'h30, 7'h40, 7'h12}, 4'h7, 4'h0, 1'b0};
    vecs[6]  = '{3'd7, 32'd10000,     4'h0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'hF, 4'h0, 1'b1};
    vecs[7]  = '{3'd3, 32'd9999,      4'h0, {7'h10, 7'h10, 7'h10, 7'h10}, 4'hF, 4'h0, 1'b0};
    vecs[8]  = '{3'd7, 32'd0,         4'h0, {7'h00, 7'h00, 7'h00, 7'h40}, 4'h1, 4'h0, 1'b0};
    vecs[9]  = '{3'd5, 32'hFFFF_0000, 4'h0, {7'h00, 7'h00, 7'h00, 7'h40}, 4'h1, 4'h0, 1'b0};
    vecs[10] = '{3'd3, 32'hFFFF_FFFF, 4'h0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'hF, 4'h0, 1'b1};

    // Reset state, then release and confirm every digit shows 0.
    repeat (3) @(posedge clk); #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    reset_n = 1'b1;
    check_frame("post_rst", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0, 1'b0);
    rd(2'd1, rv); check("rst_ctrl", rv, 32'h1);
    rd(2'd0, rv); check("rst_value", rv, 32'h0);

    foreach (vecs[i])
      run_vec($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].value, vecs[i].dpm,
              vecs[i].eseg, vecs[i].elit, vecs[i].edpl, vecs[i].eovf);

    // BUSY width and shadow persistence while converting.
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h5678);
    repeat (3) @(posedge clk);
    wr(2'd1, 32'd3);
    repeat (3) @(posedge clk);
    wr(2'd0, 32'd1234);
    monitor({7'h12, 7'h02, 7'h78, 7'h00}, cnt, first, last, pok, saw);
    check("busy_cycles", cnt, 32);
    check("busy_first", first, 1);
    check("busy_persist", pok, 1'b1);
    check_frame("dec1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0, 1'b0);

    // Restart while busy: 1234 must never reach the display.
    wr(2'd0, 32'd8888);
    wait_idle();
    repeat (3) @(posedge clk);
    wr(2'd0, 32'd1234);
    repeat (8) @(posedge clk);
    wr(2'd0, 32'd42);
    monitor({7'h00, 7'h00, 7'h00, 7'h00}, cnt, first, last, pok, saw);
    check("restart_cycles", cnt, 32);
    check("restart_last", last, 32);
    check("restart_persist", pok, 1'b1);
    check("restart_no_1234", saw, 1'b0);
    check_frame("dec42", {7'h40, 7'h40, 7'h19, 7'h24}, 4'hF, 4'h0, 1'b0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, rv); check("status_ro", rv, 32'h0);
    rd(2'd0, rv); check("value_rb", rv, 32'd42);

    // Randomized against the arithmetic model.
    for (int r = 0; r < 12; r++) begin
      c  = 3'($urandom_range(0, 7));
      dm = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: val = $urandom_range(0, 9999);
        1: val = $urandom_range(0, 99);
        2: val = $urandom;
        default: val = $urandom_range(9990, 10010);
      endcase
      model(c, val, dm, ms, ml, md, mo);
      run_vec($sformatf("rand%0d", r), c, val, dm, ms, ml, md, mo);
    end

    // Reset asserted in the middle of a conversion.
    wr(2'd2, 32'hF);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd1234);
    repeat (5) @(posedge clk); #1;
    sel = 1'b0; addr = 2'd0; #1;
    check("rdata_sel_low", rdata, 32'h0);
    reset_n = 1'b0; #1;
    check("abort_an", an, 4'hF);
    check("abort_seg", seg, 7'h7F);
    check("abort_dp", dp, 1'b1);
    sel = 1'b1; addr = 2'd3; #1;
    check("abort_status", rdata, 32'h0);
    sel = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("hold_an", an, 4'hF);
    check("hold_seg", seg, 7'h7F);
    reset_n = 1'b1;
    rd(2'd1, rv); check("abort_ctrl", rv, 32'h1);
    rd(2'd0, rv); check("abort_value", rv, 32'h0);
    rd(2'd2, rv); check("abort_dpmask", rv, 32'h0);
    repeat (40) @(posedge clk);
    check_frame("abort_frame", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
